// File: rtl/word_fetch_pkg.sv
// rtl/word_fetch_pkg.sv - shared types and constants for the word fetcher
package word_fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  localparam int HALF_BYTES  = 2;
  localparam int WORD_HALVES = 2;
  localparam int HALF_CNT_W  = 33;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous show-ahead word FIFO; push and pop may coincide even when full
module fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/word_fetcher.sv
// rtl/word_fetcher.sv - prefetching 16-bit Avalon reader that streams reassembled 32-bit words
// Optional stall counter enabled by WORD_FETCH_STATS_EN.
module word_fetcher
  import word_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_ptr,
  input  logic [31:0] size,
  output logic        busy,
  output logic        done,
  output logic [31:0] address,
  output logic        read,
  input  logic [15:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] stall_cycles
);

  localparam int PW = cnt_w(MAX_PENDING);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic                  read_q, read_d;
  logic [HALF_CNT_W-1:0] issue_left_q, issue_left_d;
  logic [HALF_CNT_W-1:0] recv_left_q, recv_left_d;
  logic [PW-1:0]         pending_q, pending_d;
  logic                  half_q, half_d;
  logic [15:0]           low_q, low_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic          accept, resp, push, pop, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_count_d;
  int            credit;

  assign accept = read_q && !waitrequest;
  assign resp   = readdatavalid && (state_q == FETCH) && (recv_left_q != '0);
  assign push   = resp && half_q;
  assign pop    = word_valid && word_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    recv_left_d  = recv_left_q;
    pending_d    = pending_q;
    half_d       = half_q;
    low_d        = low_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size != '0) begin
            state_d      = FETCH;
            addr_d       = base_ptr;
            issue_left_d = HALF_CNT_W'(size) * HALF_CNT_W'(WORD_HALVES);
            recv_left_d  = HALF_CNT_W'(size) * HALF_CNT_W'(WORD_HALVES);
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (accept) begin
          addr_d       = addr_q + 32'(HALF_BYTES);
          issue_left_d = issue_left_q - HALF_CNT_W'(1);
        end
        if (resp) begin
          recv_left_d = recv_left_q - HALF_CNT_W'(1);
          half_d      = !half_q;
          if (!half_q) low_d = readdata;
        end
        pending_d = pending_q + PW'(accept) - PW'(resp);
        if (recv_left_q == '0) state_d = DRAIN;
      end
      DRAIN:   if (fifo_empty) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Credit counts every halfword already promised a FIFO slot, so the
    // next issued read can never overflow the buffer.
    fifo_count_d = fifo_count + CW'(push) - CW'(pop);
    credit = int'(pending_d) + 2 * int'(fifo_count_d) + int'(half_d);
    read_d = (read_q && waitrequest) ||
             ((state_d == FETCH) && (issue_left_d != '0) &&
              (int'(pending_d) < MAX_PENDING) && (credit < 2 * FIFO_DEPTH));
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      read_q       <= 1'b0;
      issue_left_q <= '0;
      recv_left_q  <= '0;
      pending_q    <= '0;
      half_q       <= 1'b0;
      low_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      issue_left_q <= issue_left_d;
      recv_left_q  <= recv_left_d;
      pending_q    <= pending_d;
      half_q       <= half_d;
      low_q        <= low_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({readdata, low_q}),
    .pop       (pop),
    .pop_data  (word_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign address    = addr_q;
  assign read       = read_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef WORD_FETCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) stall_d = '0;
    else if (read_q && waitrequest && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_word_fetcher.sv
// tb/tb_word_fetcher.sv - self-checking bench for word_fetcher with Avalon slave and stream scoreboard
// Stats checks follow WORD_FETCH_STATS_EN.
module tb_word_fetcher;

  localparam int MAX_PENDING = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] base_ptr, size;
  logic        busy, done, read;
  logic [31:0] address, word_data, stall_cycles;
  logic [15:0] readdata = '0;
  logic        waitrequest = 1'b0;
  logic        readdatavalid = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b0;

  always #5 clk = ~clk;

  word_fetcher #(.FIFO_DEPTH(8), .MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .reset(reset), .start(start), .base_ptr(base_ptr), .size(size),
    .busy(busy), .done(done), .address(address), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .stall_cycles(stall_cycles)
  );

  typedef struct {int due; logic [15:0] data; int gen;} resp_t;

  resp_t       rq[$];
  logic [31:0] exp_addr[$], exp_word[$], acc_log[$], got_words[$];
  logic [31:0] mem_w [logic [31:0]];
  int errors = 0, checks = 0, cyc = 0;
  int gen = 0, pend = 0, max_pend_seen = 0, done_cnt = 0;
  int stall_model = 0, stall_budget = 0, wait_mode = 0, lat_min = 2, lat_max = 2;
  bit ready_en = 1'b1, ready_rand = 1'b0, hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(logic [31:0] a);
    if (mem_w.exists(a)) return mem_w[a];
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [15:0] half_at(logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Avalon slave, stream sink and scoreboard share one process so that
  // inputs for the next edge are chosen after the checks on this cycle.
  always @(negedge clk) begin
    resp_t e;
    bit    wr;
    if (reset) begin
      gen++;
      pend = 0;
      exp_addr.delete();
      exp_word.delete();
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      hold_prev     = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_read", read, 1'b1);
        chk("hold_addr", address, hold_addr);
      end
      wr = 1'b0;
      if (read) begin
        if (wait_mode == 1) wr = 1'($urandom_range(0, 1));
        else if (stall_budget > 0) begin wr = 1'b1; stall_budget--; end
      end
      waitrequest = wr;
      hold_prev   = read && wr;
      hold_addr   = address;
      if (read && wr) stall_model++;
      if (read && !wr) begin
        acc_log.push_back(address);
        if (exp_addr.size() == 0) chk("extra_read", address, 32'hFFFF_FFFF);
        else chk("read_addr", address, exp_addr.pop_front());
        e.due  = cyc + int'($urandom_range(lat_max, lat_min));
        e.data = half_at(address);
        e.gen  = gen;
        rq.push_back(e);
        pend++;
      end
      readdatavalid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        e = rq.pop_front();
        readdatavalid = 1'b1;
        readdata      = e.data;
        if (e.gen == gen) pend--;
      end
      if (pend > max_pend_seen) max_pend_seen = pend;
      if (pend > MAX_PENDING) chk("pending_limit", pend, MAX_PENDING);
      word_ready = ready_en && (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (word_valid && word_ready) begin
        got_words.push_back(word_data);
        if (exp_word.size() == 0) chk("extra_word", word_data, 32'hDEAD_BEEF);
        else chk("word_data", word_data, exp_word.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_words_left", exp_word.size(), 0);
        chk("done_addr_left", exp_addr.size(), 0);
        chk("done_busy", busy, 1'b1);
`ifdef WORD_FETCH_STATS_EN
        chk("done_stall", stall_cycles, stall_model);
`else
        chk("done_stall_tied", stall_cycles, 0);
`endif
      end
    end
  end

  task automatic do_start(logic [31:0] b, logic [31:0] s, bit track);
    @(posedge clk); #1;
    start = 1'b1; base_ptr = b; size = s;
    if (track) begin
      stall_model = 0;
      for (int i = 0; i < int'(s); i++) begin
        exp_word.push_back(word_at(b + 32'(4 * i)));
        exp_addr.push_back(b + 32'(4 * i));
        exp_addr.push_back(b + 32'(4 * i + 2));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int target, int limit, string name);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, done_cnt, target);
  endtask

  initial begin
    logic [31:0] lit_addr [6];
    logic [31:0] lit_word [3];
    int a0, w0, tgt, n;
    lit_addr = '{32'h1000, 32'h1002, 32'h1004, 32'h1006, 32'h1008, 32'h100A};
    lit_word = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    mem_w[32'h1000] = 32'h3F80_0000;
    mem_w[32'h1004] = 32'h4000_0000;
    mem_w[32'h1008] = 32'h4040_0000;
    reset = 1'b1; start = 1'b0; base_ptr = '0; size = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_addr", address, 32'h0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_stall", stall_cycles, 32'h0);

    // basic three-word transfer pinned against literal values
    a0 = acc_log.size(); w0 = got_words.size();
    do_start(32'h1000, 32'd3, 1'b1);
    wait_done(1, 200, "basic_done");
    repeat (4) @(negedge clk);
    #1 chk("basic_one_done", done_cnt, 1);
    chk("basic_busy_after", busy, 1'b0);
    chk("basic_nreads", acc_log.size() - a0, 6);
    for (int i = 0; i < 6; i++)
      if (acc_log.size() > a0 + i) chk("basic_addr_lit", acc_log[a0 + i], lit_addr[i]);
    chk("basic_nwords", got_words.size() - w0, 3);
    for (int i = 0; i < 3; i++)
      if (got_words.size() > w0 + i) chk("basic_word_lit", got_words[w0 + i], lit_word[i]);

    // a second start during FETCH must not disturb the address sequence
    a0 = acc_log.size(); tgt = done_cnt + 1;
    do_start(32'h2000, 32'd4, 1'b1);
    repeat (2) @(posedge clk);
    do_start(32'h9000, 32'd5, 1'b0);
    wait_done(tgt, 300, "ignored_start_done");
    repeat (3) @(negedge clk);
    #1 chk("ignored_start_nreads", acc_log.size() - a0, 8);
    chk("ignored_start_one_done", done_cnt, tgt);

    // zero size finishes quickly with no reads
    a0 = acc_log.size(); tgt = done_cnt + 1;
    do_start(32'h3000, 32'd0, 1'b1);
    wait_done(tgt, 2, "zero_done");
    repeat (3) @(negedge clk);
    #1 chk("zero_nreads", acc_log.size() - a0, 0);

    // backpressure: reads stop once the FIFO is fully credited
    ready_en = 1'b0; a0 = acc_log.size(); w0 = got_words.size(); tgt = done_cnt + 1;
    do_start(32'h4000, 32'd20, 1'b1);
    repeat (80) @(negedge clk);
    #1 chk("bp_reads_capped", acc_log.size() - a0, 16);
    chk("bp_valid", word_valid, 1'b1);
    chk("bp_read_low", read, 1'b0);
    chk("bp_no_words", got_words.size() - w0, 0);
    ready_en = 1'b1;
    wait_done(tgt, 600, "bp_done");
    chk("bp_nwords", got_words.size() - w0, 20);

    // random stalls, latency 3-6, random ready, address wrap past 2^32
    wait_mode = 1; lat_min = 3; lat_max = 6; ready_rand = 1'b1;
    max_pend_seen = 0; w0 = got_words.size(); tgt = done_cnt + 1;
    do_start(32'hFFFF_FFF0, 32'd12, 1'b1);
    wait_done(tgt, 3000, "stall_done");
    chk("stall_nwords", got_words.size() - w0, 12);
    chk("stall_pend_bound", max_pend_seen <= MAX_PENDING, 1'b1);
    wait_mode = 0; ready_rand = 1'b0;

    // reset mid-transfer with reads outstanding
    lat_min = 6; lat_max = 6;
    do_start(32'h6000, 32'd8, 1'b1);
    n = 0;
    while (pend < 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("mid_pend_reached", pend >= 2, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_read", read, 1'b0);
    chk("mid_rst_addr", address, 32'h0);
    chk("mid_rst_valid", word_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("late_resp_valid", word_valid, 1'b0);
      chk("late_resp_busy", busy, 1'b0);
    end
    lat_min = 2; lat_max = 2; w0 = got_words.size(); tgt = done_cnt + 1;
    do_start(32'h1000, 32'd3, 1'b1);
    wait_done(tgt, 200, "post_rst_done");
    chk("post_rst_nwords", got_words.size() - w0, 3);

    // stall statistics: exactly seven stalled read cycles
    stall_budget = 7; tgt = done_cnt + 1;
    do_start(32'h7000, 32'd4, 1'b1);
    wait_done(tgt, 300, "stats_done");
    repeat (3) @(negedge clk);
`ifdef WORD_FETCH_STATS_EN
    #1 chk("stats_seven_held", stall_cycles, 32'd7);
`else
    #1 chk("stats_tied_zero", stall_cycles, 32'd0);
`endif
    tgt = done_cnt + 1;
    do_start(32'h7100, 32'd2, 1'b1);
    chk("stats_cleared", stall_cycles, 32'd0);
    wait_done(tgt, 200, "stats2_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
